// File: rtl/seg7_readback_if.sv
// ----------------------------------------------------------------------------
// seg7_readback_if
// Bundles the sampled display bus and the decoded readback state of the
// seven-segment readback monitor.
//   anode[3:0]     digit enables, active-low (driven by the display side)
//   seg[6:0]       segment lines, active-low, {g,f,e,d,c,b,a}
//   clear          synchronous clear of shadow state and sticky errors
//   digits[15:0]   decoded digit values, digit i at [4i+3:4i]
//   digit_valid    per-digit "captured with a hex value"
//   digit_ovf      per-digit "last capture was the overflow pattern"
//   update/upd_idx one-cycle capture pulse and the digit it refers to
//   err_invalid    sticky: stable pattern was not hex/overflow/blank
//   err_collision  sticky: stable anode had more than one bit low
// Modports: master drives the bus and observes results, slave is the monitor.
// ----------------------------------------------------------------------------
interface seg7_readback_if;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_ovf;
    logic        update;
    logic [1:0]  upd_idx;
    logic        err_invalid;
    logic        err_collision;

    modport master (
        output anode, seg, clear,
        input  digits, digit_valid, digit_ovf, update, upd_idx,
               err_invalid, err_collision
    );

    modport slave (
        input  anode, seg, clear,
        output digits, digit_valid, digit_ovf, update, upd_idx,
               err_invalid, err_collision
    );
endinterface

// File: rtl/seg7_readback.sv
// ----------------------------------------------------------------------------
// seg7_readback
// Readback monitor for a 4-digit seven-segment display bus. The raw
// {anode,seg} lines are registered every cycle; a value must stay identical
// for STABLE_CYCLES consecutive samples before it is captured, which filters
// out switching glitches. A capture decodes the segment pattern back into a
// hex value (or overflow/blank/invalid) and updates a per-digit shadow.
// Ports:
//   clk    system clock (inputs are already in this domain)
//   rst_n  asynchronous active-low reset
//   bus    seg7_readback_if.slave (display lines in, decoded state out)
// ----------------------------------------------------------------------------
module seg7_readback #(
    parameter int unsigned STABLE_CYCLES = 4   // legal 2..255
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_readback_if.slave  bus
);

    localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
    localparam logic [10:0] S_RESET   = {4'b1111, 7'b1111111};
    localparam logic [6:0]  PAT_OVF   = 7'b0110110;
    localparam logic [6:0]  PAT_BLANK = 7'b1111111;

    // Sample register, run counter and "this run already fired" flag.
    logic [10:0] s_q, s_d;
    logic [7:0]  r_q, r_d;
    logic        done_q, done_d;

    // Shadow / output state.
    logic [3:0]  digit_q [4];
    logic [3:0]  digit_d [4];
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  ovf_q, ovf_d;
    logic        update_q, update_d;
    logic [1:0]  upd_idx_q, upd_idx_d;
    logic        err_inv_q, err_inv_d;
    logic        err_col_q, err_col_d;

    // Decode of the currently held sample.
    logic [3:0]  anode_low;
    logic [6:0]  pat;
    logic        hex_ok;
    logic [3:0]  hex_val;
    logic        one_low;
    logic [1:0]  low_idx;
    logic        fire;
    logic        restart;

    assign anode_low = ~s_q[10:7];
    assign pat       = s_q[6:0];

    always_comb begin
        hex_ok  = 1'b1;
        hex_val = 4'h0;
        case (pat)
            7'b1000000: hex_val = 4'h0;
            7'b1111001: hex_val = 4'h1;
            7'b0100100: hex_val = 4'h2;
            7'b0110000: hex_val = 4'h3;
            7'b0011001: hex_val = 4'h4;
            7'b0010010: hex_val = 4'h5;
            7'b0000010: hex_val = 4'h6;
            7'b1111000: hex_val = 4'h7;
            7'b0000000: hex_val = 4'h8;
            7'b0010000: hex_val = 4'h9;
            7'b0001000: hex_val = 4'hA;
            7'b0000011: hex_val = 4'hB;
            7'b1000110: hex_val = 4'hC;
            7'b0100001: hex_val = 4'hD;
            7'b0000110: hex_val = 4'hE;
            7'b0001110: hex_val = 4'hF;
            default:    hex_ok  = 1'b0;
        endcase
    end

    // Exactly one enable low: nonzero and a power of two.
    always_comb begin
        one_low = (anode_low != 4'b0000) &&
                  ((anode_low & (anode_low - 4'd1)) == 4'b0000);
        low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (anode_low[i]) low_idx = 2'(i);
        end
    end

    // Run tracking. A changed sample or a clear restarts qualification;
    // done_q makes a saturated run fire only once.
    always_comb begin
        s_d     = {bus.anode, bus.seg};
        restart = (s_d != s_q) || bus.clear;
        fire    = (r_q == STABLE) && !done_q;

        if (restart)           r_d = 8'd1;
        else if (r_q < STABLE) r_d = r_q + 8'd1;
        else                   r_d = r_q;

        done_d = restart ? 1'b0 : (done_q | fire);
    end

    // Capture / clear next-state.
    always_comb begin
        for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        update_d  = 1'b0;
        upd_idx_d = upd_idx_q;
        err_inv_d = err_inv_q;
        err_col_d = err_col_q;

        if (bus.clear) begin
            // Clear takes priority over a capture landing in the same cycle.
            for (int i = 0; i < 4; i++) digit_d[i] = 4'h0;
            valid_d   = 4'b0000;
            ovf_d     = 4'b0000;
            upd_idx_d = 2'd0;
            err_inv_d = 1'b0;
            err_col_d = 1'b0;
        end else if (fire && (anode_low != 4'b0000)) begin
            if (one_low) begin
                update_d  = 1'b1;
                upd_idx_d = low_idx;
                if (hex_ok) begin
                    digit_d[low_idx] = hex_val;
                    valid_d[low_idx] = 1'b1;
                    ovf_d[low_idx]   = 1'b0;
                end else if (pat == PAT_OVF) begin
                    valid_d[low_idx] = 1'b0;
                    ovf_d[low_idx]   = 1'b1;
                end else begin
                    // Blank and invalid both leave the digit unlit.
                    valid_d[low_idx] = 1'b0;
                    ovf_d[low_idx]   = 1'b0;
                    if (pat != PAT_BLANK) err_inv_d = 1'b1;
                end
            end else begin
                err_col_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= S_RESET;
            r_q       <= 8'd1;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
            valid_q   <= 4'b0000;
            ovf_q     <= 4'b0000;
            update_q  <= 1'b0;
            upd_idx_q <= 2'd0;
            err_inv_q <= 1'b0;
            err_col_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            update_q  <= update_d;
            upd_idx_q <= upd_idx_d;
            err_inv_q <= err_inv_d;
            err_col_q <= err_col_d;
        end
    end

    assign bus.digits        = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
    assign bus.digit_valid   = valid_q;
    assign bus.digit_ovf     = ovf_q;
    assign bus.update        = update_q;
    assign bus.upd_idx       = upd_idx_q;
    assign bus.err_invalid   = err_inv_q;
    assign bus.err_collision = err_col_q;

endmodule

// File: tb/tb_seg7_readback.sv
module tb_seg7_readback;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seg7_readback_if bus ();

    seg7_readback #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        bus.anode = a;
        bus.seg   = s;
    endtask

    // Run n cycles, counting update pulses and remembering the first one.
    task automatic run(input int n, output int n_upd, output int first_at,
                       output logic [1:0] idx_at);
        n_upd    = 0;
        first_at = -1;
        idx_at   = 2'd0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.update === 1'b1) begin
                if (n_upd == 0) begin
                    first_at = i;
                    idx_at   = bus.upd_idx;
                end
                n_upd++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'b1111, 7'b1111111);
        bus.clear = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.digits !== 16'h0000 || bus.digit_valid !== 4'b0 || bus.digit_ovf !== 4'b0) begin
            failures++;
            $display("FAIL reset_state digits=%h valid=%b ovf=%b required 0000/0000/0000",
                     bus.digits, bus.digit_valid, bus.digit_ovf);
        end
        checks++;
        if (bus.update !== 1'b0 || bus.upd_idx !== 2'd0 || bus.err_invalid !== 1'b0 || bus.err_collision !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags upd=%b idx=%0d inv=%b col=%b required all 0",
                     bus.update, bus.upd_idx, bus.err_invalid, bus.err_collision);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        $display("test_reset done");
    endtask

    task automatic test_hex();
        int n; int at; logic [1:0] idx;
        drive(4'b1110, 7'b0100100);
        run(4, n, at, idx);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL hex_early got %0d updates in edges 0-3, required 0", n);
        end
        tick();  // edge 4
        checks++;
        if (bus.update !== 1'b1 || bus.upd_idx !== 2'd0) begin
            failures++;
            $display("FAIL hex_update upd=%b idx=%0d required upd=1 idx=0", bus.update, bus.upd_idx);
        end
        checks++;
        if (bus.digits[3:0] !== 4'h2 || bus.digit_valid !== 4'b0001) begin
            failures++;
            $display("FAIL hex_value digit0=%h valid=%b required 2/0001", bus.digits[3:0], bus.digit_valid);
        end
        run(6, n, at, idx);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL hex_refire got %0d extra updates, required 0", n);
        end
        $display("test_hex digit0=%h valid=%b", bus.digits[3:0], bus.digit_valid);
    endtask

    task automatic test_glitch();
        int n; int at; logic [1:0] idx;
        drive(4'b1101, 7'b0000011);
        run(3, n, at, idx);
        drive(4'b1101, 7'b1000000);
        run(10, n, at, idx);
        checks++;
        if (n !== 1 || at !== 4 || idx !== 2'd1) begin
            failures++;
            $display("FAIL glitch_updates count=%0d at=%0d idx=%0d required 1/4/1", n, at, idx);
        end
        checks++;
        if (bus.digits[7:0] !== 8'h02 || bus.digit_valid !== 4'b0011) begin
            failures++;
            $display("FAIL glitch_value digits[7:0]=%h valid=%b required 02/0011",
                     bus.digits[7:0], bus.digit_valid);
        end
        $display("test_glitch digit1=%h updates=%0d", bus.digits[7:4], n);
    endtask

    task automatic test_ovf_blank();
        int n; int at; logic [1:0] idx;
        drive(4'b1011, 7'b0001110);
        run(6, n, at, idx);
        checks++;
        if (bus.digits[11:8] !== 4'hF || bus.digit_valid !== 4'b0111 || n !== 1 || idx !== 2'd2) begin
            failures++;
            $display("FAIL hexF digit2=%h valid=%b updates=%0d idx=%0d required F/0111/1/2",
                     bus.digits[11:8], bus.digit_valid, n, idx);
        end
        drive(4'b1011, 7'b0110110);
        run(6, n, at, idx);
        checks++;
        if (bus.digit_ovf !== 4'b0100 || bus.digit_valid !== 4'b0011 || bus.digits[11:8] !== 4'hF || n !== 1) begin
            failures++;
            $display("FAIL overflow ovf=%b valid=%b digit2=%h updates=%0d required 0100/0011/F/1",
                     bus.digit_ovf, bus.digit_valid, bus.digits[11:8], n);
        end
        drive(4'b1011, 7'b1111111);
        run(6, n, at, idx);
        checks++;
        if (bus.digit_ovf !== 4'b0000 || bus.digit_valid !== 4'b0011 || bus.digits[11:8] !== 4'hF || n !== 1) begin
            failures++;
            $display("FAIL blank ovf=%b valid=%b digit2=%h updates=%0d required 0000/0011/F/1",
                     bus.digit_ovf, bus.digit_valid, bus.digits[11:8], n);
        end
        checks++;
        if (bus.err_invalid !== 1'b0) begin
            failures++;
            $display("FAIL blank_noerr err_invalid=%b required 0", bus.err_invalid);
        end
        $display("test_ovf_blank ovf=%b valid=%b", bus.digit_ovf, bus.digit_valid);
    endtask

    task automatic test_errors();
        int n; int at; logic [1:0] idx;
        drive(4'b1100, 7'b1000000);
        run(6, n, at, idx);
        checks++;
        if (bus.err_collision !== 1'b1 || n !== 0 || bus.digit_valid !== 4'b0011 || bus.err_invalid !== 1'b0) begin
            failures++;
            $display("FAIL collision col=%b updates=%0d valid=%b inv=%b required 1/0/0011/0",
                     bus.err_collision, n, bus.digit_valid, bus.err_invalid);
        end
        drive(4'b0111, 7'b1010101);
        run(6, n, at, idx);
        checks++;
        if (bus.err_invalid !== 1'b1 || n !== 1 || idx !== 2'd3 || bus.digit_valid !== 4'b0011) begin
            failures++;
            $display("FAIL invalid inv=%b updates=%0d idx=%0d valid=%b required 1/1/3/0011",
                     bus.err_invalid, n, idx, bus.digit_valid);
        end
        drive(4'b1111, 7'b1111111);
        run(8, n, at, idx);
        checks++;
        if (bus.err_invalid !== 1'b1 || bus.err_collision !== 1'b1 || n !== 0) begin
            failures++;
            $display("FAIL sticky inv=%b col=%b updates=%0d required 1/1/0",
                     bus.err_invalid, bus.err_collision, n);
        end
        $display("test_errors inv=%b col=%b", bus.err_invalid, bus.err_collision);
    endtask

    task automatic test_clear_capture();
        int n; int at; logic [1:0] idx;
        drive(4'b1110, 7'b0011001);
        run(4, n, at, idx);
        bus.clear = 1'b1;
        tick();  // would-be capture edge
        bus.clear = 1'b0;
        checks++;
        if (bus.update !== 1'b0 || bus.digits !== 16'h0000 || bus.digit_valid !== 4'b0 ||
            bus.digit_ovf !== 4'b0 || bus.err_invalid !== 1'b0 || bus.err_collision !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins upd=%b digits=%h valid=%b ovf=%b inv=%b col=%b required all 0",
                     bus.update, bus.digits, bus.digit_valid, bus.digit_ovf,
                     bus.err_invalid, bus.err_collision);
        end
        run(6, n, at, idx);
        checks++;
        if (n !== 1 || at !== 3 || idx !== 2'd0 || bus.digits !== 16'h0004 || bus.digit_valid !== 4'b0001) begin
            failures++;
            $display("FAIL clear_requal updates=%0d at=%0d idx=%0d digits=%h valid=%b required 1/3/0/0004/0001",
                     n, at, idx, bus.digits, bus.digit_valid);
        end
        $display("test_clear_capture digits=%h", bus.digits);
    endtask

    task automatic test_async_reset();
        int n; int at; logic [1:0] idx;
        drive(4'b1101, 7'b0010010);
        run(2, n, at, idx);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.digits !== 16'h0000 || bus.digit_valid !== 4'b0 || bus.update !== 1'b0) begin
            failures++;
            $display("FAIL async_reset digits=%h valid=%b upd=%b required 0000/0000/0",
                     bus.digits, bus.digit_valid, bus.update);
        end
        tick();
        rst_n = 1'b1;
        run(8, n, at, idx);
        checks++;
        if (n !== 1 || at !== 4 || idx !== 2'd1 || bus.digits !== 16'h0050 || bus.digit_valid !== 4'b0010) begin
            failures++;
            $display("FAIL reset_requal updates=%0d at=%0d idx=%0d digits=%h valid=%b required 1/4/1/0050/0010",
                     n, at, idx, bus.digits, bus.digit_valid);
        end
        $display("test_async_reset digits=%h", bus.digits);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_hex();
        test_glitch();
        test_ovf_blank();
        test_errors();
        test_clear_capture();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Display-bus readback monitor for the 4-digit seven-segment interface. It samples the active-low `anode`/`seg` lines driven by the display encoder and filters out switching glitches. It decodes each digit's segment pattern back into a 4-bit hex value or an overflow marker, and holds a per-digit shadow register. It sits alongside the display driver on the board top and gives self-check logic and the bench a cycle-accurate view of what the display is actually showing.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is captured. Legal range is 2–255.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `anode` in 4: digit enables, active-low. Bit i low selects digit i.
- `seg` in 7: segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- `clear` in 1: synchronous. Zeroes the shadow registers, valid flags and sticky errors.
- `digits` out 16: decoded values. Digit i occupies bits [4i+3:4i].
- `digit_valid` out 4: digit i has been captured with a hex value.
- `digit_ovf` out 4: digit i was last captured showing the overflow pattern.
- `update` out 1: one-cycle pulse on every capture.
- `upd_idx` out 2: index of the digit updated with `update`.
- `err_invalid` out 1: sticky. A stable pattern was neither hex, overflow nor blank.
- `err_collision` out 1: sticky. A stable anode value had more than one bit low.

## Operation
- Decode table, seg → value:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
- Special patterns:
  - 0110110 is overflow.
  - 1111111 is blank.
  - Any other pattern is invalid.
- Input stage: `{anode,seg}` is registered into sample register S every cycle. No synchronizer, because the inputs are in the `clk` domain.
- Run counter R (8 bits):
  - R = 1 when S loads a value different from its previous contents.
  - Otherwise R increments, saturating at STABLE_CYCLES.
- Capture fires exactly once per stable run, on the cycle R reaches STABLE_CYCLES. A run longer than that never re-fires.
- Capture actions, by anode value in S:
  - Anode 1111 (idle): no capture, no `update`, no error.
  - Exactly one anode bit low, index i: `upd_idx`=i and `update`=1. Then, by pattern:
    - Hex: `digits[i]`=value, `digit_valid[i]`=1, `digit_ovf[i]`=0.
    - Overflow: `digit_ovf[i]`=1, `digit_valid[i]`=0, `digits[i]` unchanged.
    - Blank: `digit_valid[i]`=0, `digit_ovf[i]`=0, `digits[i]` unchanged.
    - Invalid: same register updates as blank, plus `err_invalid`=1.
  - Two or more anode bits low: `err_collision`=1. No digit state changes and no `update`.
- `clear` wins over a capture in the same cycle: everything clears and `update` stays 0. `clear` also resets R to 1, so a value already stable must be re-qualified for STABLE_CYCLES samples.
- Sticky errors clear only on `clear` or reset.

## Timing
- Reset values:
  - Outputs: `digits`=0, `digit_valid`=0, `digit_ovf`=0, `update`=0, `upd_idx`=0, `err_*`=0.
  - Internal: S=`{4'b1111,7'b1111111}`, R=1.
- Latency: if `{anode,seg}` is presented before clock edge 0 and held through edge STABLE_CYCLES−1, then `update` and the new `digits`/flags are valid after edge STABLE_CYCLES. With the default, that is 4 edges after first sampling.
- `update` is high for exactly one cycle. `upd_idx` holds its last value otherwise.
- A glitch of 1 to STABLE_CYCLES−1 cycles restarts R and produces no capture.
- Reset asserted mid-run returns everything to reset values immediately (asynchronous). A run in progress is discarded.
- A value stable across reset deassertion is sampled fresh and needs STABLE_CYCLES edges after deassertion before capture.

## Test plan
- Hex capture: anode=1110, seg=0100100 held 4 cycles → `update` pulses after edge 4, `upd_idx`=0, `digits[3:0]`=2, `digit_valid`=0001.
- Glitch rejection: anode=1101, seg=0000011 held 3 cycles, then seg=1000000 held 10 cycles → no capture of b. A single `update` for value 0 on digit 1. No re-fire during cycles 5–10.
- Overflow and blank: digit 2 shows 0001110 (F), then 0110110, then 1111111, each held 6 cycles → `digit_ovf`=0100 with `digits[11:8]` still F. Then `digit_valid[2]`=0 and `digit_ovf[2]`=0.
- Errors: anode=1100 held 4 cycles → `err_collision`=1 and no `update`. Then anode=0111 with seg=1010101 → `err_invalid`=1. Both remain set until `clear`.
- Clear vs. capture: `clear` asserted on the capture cycle → `update`=0 and all state zero. With the input still held, a capture occurs 4 cycles after `clear` drops.
- Async reset mid-run: `rst_n` low after 2 stable cycles → outputs zero immediately. After release, with the input held, capture occurs 4 edges later.
